counter_arbiter: RTL and testbench
==================================

COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum grant length in cycles (legal 1..15).
REQ-002 Port: clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: req  input  4  per-requester access request; bit i held high while requester i wants the counter.
REQ-005 Port: inc  input  4  per-requester increment strobe; meaningful only while that requester is granted.
REQ-006 Port: gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-007 Port: owner  output  2  index of current grant holder, registered; holds last owner when gnt is zero.
REQ-008 Port: up  output  1  increment strobe to the shared counter, combinational from registered gnt and inputs.
REQ-009 Port: burst_cnt  output  4  cycles elapsed in the current grant, registered.
REQ-010 Port: busy  output  1  high in GRANT and GAP states.

Function
REQ-011 FSM states: IDLE, GRANT, GAP; encoding free, exactly these three states.
REQ-012 IDLE: if req != 0, next state GRANT, gnt set to the winner of round-robin arbitration; else stay IDLE.
REQ-013 Round-robin: search starts at (owner+1) mod 4 and proceeds upward with wrap; first set req bit wins.
REQ-014 Grant takes effect the cycle after the winning req is sampled (1-cycle request-to-grant latency).
REQ-015 GRANT: burst_cnt increments by 1 each cycle, starting at 0 in the first granted cycle.
REQ-016 GRANT ends on the edge where req[owner] is sampled low, or where burst_cnt == MAX_BURST-1, whichever first.
REQ-017 On GRANT end: gnt cleared to 0, burst_cnt cleared to 0, owner retained, next state GAP.
REQ-018 GAP: exactly one cycle, gnt = 0, up = 0; then IDLE, or directly GRANT when req != 0 (arbitration as REQ-013, at the same edge).
REQ-019 up = gnt[owner] & req[owner] & inc[owner]; inc from non-owners ignored.
REQ-020 up low in the final granted cycle if req[owner] is already low in that cycle (REQ-019 applies, no special case).
REQ-021 Simultaneous requests: exactly one grant; the others wait, no request lost while held.
REQ-022 Single requester holding req continuously: bursts of MAX_BURST cycles separated by one GAP cycle, same owner re-granted.
REQ-023 req dropped and re-raised by a non-owner while waiting: no effect on fairness; order still from REQ-013.
REQ-024 gnt one-hot or zero at all times; never two bits set.
REQ-025 burst_cnt saturates never; width 4 covers MAX_BURST <= 15.

Reset
REQ-026 On rst high at a clock edge: state IDLE, gnt 0, owner 3 (so requester 0 has first priority), burst_cnt 0; busy 0, up 0.
REQ-027 rst mid-burst: grant aborted at that edge, no GAP cycle; first post-reset arbitration from REQ-026 values.
REQ-028 rst dominates all other inputs in the same cycle.

Verification
REQ-029 Reset then req=4'b0001, inc=4'b0001 held 6 cycles -> gnt=0001 cycles 2-5 (burst_cnt 0..3), up high 4 cycles, GAP at cycle 6, re-grant to 0 at cycle 7.
REQ-030 req=4'b1111 held -> grant order 0,1,2,3,0, each 4 cycles, one GAP cycle between, gnt never multi-hot.
REQ-031 req=4'b0100 for 2 cycles then dropped, inc=4'b0100 -> gnt=0100 for 2 cycles, up pulses 1 cycle (second cycle req low), GAP, IDLE.
REQ-032 Owner 1 granted, inc=4'b1101 -> up follows inc[1] only; inc[0],inc[2],inc[3] never reach up.
REQ-033 rst asserted at burst_cnt=2 with owner 2 -> next cycle gnt=0, busy=0, owner=3; req=4'b0101 then grants 0 first.
REQ-034 MAX_BURST=1, req=4'b0011 held -> alternating 1-cycle grants to 0 and 1 separated by single GAP cycles.

Source files
------------

// File: rtl/counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : counter_arbiter
// Brief    : Round-robin arbiter granting one of four requesters bounded
//            bursts of access to a shared counter's increment strobe.
// Revision : 1.0 - initial release
// ============================================================================
module counter_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] inc,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       up,
    output logic [3:0] burst_cnt,
    output logic       busy
);

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_GRANT  = 2'd1;
    localparam logic [1:0] C_ST_GAP    = 2'd2;
    localparam logic [3:0] C_LAST_BEAT = 4'(MAX_BURST - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] owner_q, owner_d;
    logic [3:0] burst_q, burst_d;

    logic       w_any_req;
    logic       w_grant_end;
    logic [1:0] w_winner;

    // Search begins just above the last owner, so a requester that has just
    // been served drops to the back of the queue.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_any_req   = |req;
    assign w_winner    = rr_pick(req, owner_q);
    assign w_grant_end = !req[owner_q] || (burst_q == C_LAST_BEAT);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        burst_d = burst_q;
        case (state_q)
            C_ST_IDLE, C_ST_GAP: begin
                burst_d = 4'd0;
                if (w_any_req) begin
                    state_d = C_ST_GRANT;
                    gnt_d   = 4'b0001 << w_winner;
                    owner_d = w_winner;
                end else begin
                    state_d = C_ST_IDLE;
                    gnt_d   = 4'b0000;
                end
            end
            C_ST_GRANT: begin
                if (w_grant_end) begin
                    state_d = C_ST_GAP;
                    gnt_d   = 4'b0000;
                    burst_d = 4'd0;
                end else begin
                    burst_d = burst_q + 4'd1;
                end
            end
            default: begin
                state_d = C_ST_IDLE;
                gnt_d   = 4'b0000;
                burst_d = 4'd0;
            end
        endcase
    end

    // Owner resets to 3 so requester 0 is first in line after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_ST_IDLE;
            gnt_q   <= 4'b0000;
            owner_q <= 2'd3;
            burst_q <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign burst_cnt = burst_q;
    assign busy      = (state_q == C_ST_GRANT) || (state_q == C_ST_GAP);
    assign up        = gnt_q[owner_q] & req[owner_q] & inc[owner_q];

endmodule
`default_nettype wire

// File: tb/tb_counter_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_counter_arbiter
// Brief    : Scenario-driven scoreboard bench for counter_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic [3:0] burst;
        logic       busy;
        logic       up;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] inc;
        exp_t       e;
    } step_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] inc;
    logic [3:0] gnt, gnt1;
    logic [1:0] owner, owner1;
    logic       up, up1;
    logic [3:0] burst_cnt, burst_cnt1;
    logic       busy, busy1;

    exp_t obs0, obs1;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    assign obs0 = {gnt, owner, burst_cnt, busy, up};
    assign obs1 = {gnt1, owner1, burst_cnt1, busy1, up1};

    always #5 clk = ~clk;

    counter_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .inc(inc),
        .gnt(gnt), .owner(owner), .up(up), .burst_cnt(burst_cnt), .busy(busy)
    );

    counter_arbiter #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .inc(inc),
        .gnt(gnt1), .owner(owner1), .up(up1), .burst_cnt(burst_cnt1), .busy(busy1)
    );

    function automatic exp_t mk(input int g, input int o, input int b, input int bz, input int u);
        mk = {4'(g), 2'(o), 4'(b), 1'(bz), 1'(u)};
    endfunction

    function automatic step_t st(input int r, input int q, input int i, input exp_t e);
        st = {1'(r), 4'(q), 4'(i), e};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; inc = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step_t s[$];
        exp_t  e;
        rst = 1'b1; req = 4'b1111; inc = 4'b1111;
        tick();
        s.push_back(st(1, 'b1111, 'b1111, mk(0, 3, 0, 0, 0)));
        s.push_back(st(1, 'b1111, 'b1111, mk(0, 3, 0, 0, 0)));
        s.push_back(st(0, 'b0000, 'b1111, mk(0, 3, 0, 0, 0)));
        s.push_back(st(0, 'b0000, 'b0000, mk(0, 3, 0, 0, 0)));
        foreach (s[c]) begin
            rst = s[c].rst; req = s[c].req; inc = s[c].inc;
            sb.push_back(s[c].e);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs0 !== e) begin
                n_errors++;
                $display("FAIL reset cyc=%0d gnt/owner/burst/busy/up got=%b want=%b", c, obs0, e);
            end
            tick();
        end
    endtask

    task automatic test_single();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(st(0, 'b0001, 'b0001, mk(0, 3, 0, 0, 0)));
        for (int k = 0; k < 4; k++) s.push_back(st(0, 'b0001, 'b0001, mk('b0001, 0, k, 1, 1)));
        s.push_back(st(0, 'b0001, 'b0001, mk(0, 0, 0, 1, 0)));
        s.push_back(st(0, 'b0001, 'b0001, mk('b0001, 0, 0, 1, 1)));
        s.push_back(st(0, 'b0000, 'b0001, mk('b0001, 0, 1, 1, 0)));
        s.push_back(st(0, 'b0000, 'b0001, mk(0, 0, 0, 1, 0)));
        s.push_back(st(0, 'b0000, 'b0000, mk(0, 0, 0, 0, 0)));
        foreach (s[c]) begin
            rst = s[c].rst; req = s[c].req; inc = s[c].inc;
            sb.push_back(s[c].e);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs0 !== e) begin
                n_errors++;
                $display("FAIL single cyc=%0d gnt/owner/burst/busy/up got=%b want=%b", c, obs0, e);
            end
            tick();
        end
    endtask

    task automatic test_all_req();
        step_t s[$];
        exp_t  e;
        int    o;
        do_reset();
        s.push_back(st(0, 'b1111, 'b1111, mk(0, 3, 0, 0, 0)));
        for (int g = 0; g < 5; g++) begin
            o = g % 4;
            for (int k = 0; k < 4; k++) s.push_back(st(0, 'b1111, 'b1111, mk(1 << o, o, k, 1, 1)));
            if (g < 4) s.push_back(st(0, 'b1111, 'b1111, mk(0, o, 0, 1, 0)));
        end
        s.push_back(st(0, 'b0000, 'b0000, mk(0, 0, 0, 1, 0)));
        s.push_back(st(0, 'b0000, 'b0000, mk(0, 0, 0, 0, 0)));
        foreach (s[c]) begin
            rst = s[c].rst; req = s[c].req; inc = s[c].inc;
            sb.push_back(s[c].e);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs0 !== e) begin
                n_errors++;
                $display("FAIL all_req cyc=%0d gnt/owner/burst/busy/up got=%b want=%b", c, obs0, e);
            end
            tick();
        end
    endtask

    task automatic test_drop();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(st(0, 'b0100, 'b0100, mk(0, 3, 0, 0, 0)));
        s.push_back(st(0, 'b0100, 'b0100, mk('b0100, 2, 0, 1, 1)));
        s.push_back(st(0, 'b0000, 'b0100, mk('b0100, 2, 1, 1, 0)));
        s.push_back(st(0, 'b0000, 'b0100, mk(0, 2, 0, 1, 0)));
        s.push_back(st(0, 'b0000, 'b0000, mk(0, 2, 0, 0, 0)));
        foreach (s[c]) begin
            rst = s[c].rst; req = s[c].req; inc = s[c].inc;
            sb.push_back(s[c].e);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs0 !== e) begin
                n_errors++;
                $display("FAIL drop cyc=%0d gnt/owner/burst/busy/up got=%b want=%b", c, obs0, e);
            end
            tick();
        end
    endtask

    task automatic test_inc_mask();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(st(0, 'b0010, 'b1101, mk(0, 3, 0, 0, 0)));
        s.push_back(st(0, 'b0010, 'b1101, mk('b0010, 1, 0, 1, 0)));
        s.push_back(st(0, 'b0010, 'b1111, mk('b0010, 1, 1, 1, 1)));
        s.push_back(st(0, 'b0010, 'b1101, mk('b0010, 1, 2, 1, 0)));
        s.push_back(st(0, 'b0010, 'b0010, mk('b0010, 1, 3, 1, 1)));
        s.push_back(st(0, 'b0000, 'b1111, mk(0, 1, 0, 1, 0)));
        s.push_back(st(0, 'b0000, 'b0000, mk(0, 1, 0, 0, 0)));
        foreach (s[c]) begin
            rst = s[c].rst; req = s[c].req; inc = s[c].inc;
            sb.push_back(s[c].e);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs0 !== e) begin
                n_errors++;
                $display("FAIL inc_mask cyc=%0d gnt/owner/burst/busy/up got=%b want=%b", c, obs0, e);
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(st(0, 'b1011, 'b0000, mk(0, 3, 0, 0, 0)));
        s.push_back(st(0, 'b1001, 'b0000, mk('b0001, 0, 0, 1, 0)));
        s.push_back(st(0, 'b1011, 'b0000, mk('b0001, 0, 1, 1, 0)));
        s.push_back(st(0, 'b1010, 'b0000, mk('b0001, 0, 2, 1, 0)));
        s.push_back(st(0, 'b1011, 'b0000, mk(0, 0, 0, 1, 0)));
        s.push_back(st(0, 'b1001, 'b0000, mk('b0010, 1, 0, 1, 0)));
        s.push_back(st(0, 'b1001, 'b0000, mk(0, 1, 0, 1, 0)));
        s.push_back(st(0, 'b0000, 'b0000, mk('b1000, 3, 0, 1, 0)));
        s.push_back(st(0, 'b0000, 'b0000, mk(0, 3, 0, 1, 0)));
        s.push_back(st(0, 'b0000, 'b0000, mk(0, 3, 0, 0, 0)));
        foreach (s[c]) begin
            rst = s[c].rst; req = s[c].req; inc = s[c].inc;
            sb.push_back(s[c].e);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs0 !== e) begin
                n_errors++;
                $display("FAIL fairness cyc=%0d gnt/owner/burst/busy/up got=%b want=%b", c, obs0, e);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(st(0, 'b0100, 'b0000, mk(0, 3, 0, 0, 0)));
        s.push_back(st(0, 'b0100, 'b0000, mk('b0100, 2, 0, 1, 0)));
        s.push_back(st(0, 'b0100, 'b0000, mk('b0100, 2, 1, 1, 0)));
        s.push_back(st(1, 'b0100, 'b0100, mk('b0100, 2, 2, 1, 1)));
        s.push_back(st(0, 'b0101, 'b0000, mk(0, 3, 0, 0, 0)));
        s.push_back(st(0, 'b0101, 'b0000, mk('b0001, 0, 0, 1, 0)));
        s.push_back(st(0, 'b0000, 'b0000, mk('b0001, 0, 1, 1, 0)));
        s.push_back(st(0, 'b0000, 'b0000, mk(0, 0, 0, 1, 0)));
        s.push_back(st(0, 'b0000, 'b0000, mk(0, 0, 0, 0, 0)));
        foreach (s[c]) begin
            rst = s[c].rst; req = s[c].req; inc = s[c].inc;
            sb.push_back(s[c].e);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs0 !== e) begin
                n_errors++;
                $display("FAIL reset_mid cyc=%0d gnt/owner/burst/busy/up got=%b want=%b", c, obs0, e);
            end
            tick();
        end
    endtask

    task automatic test_max_burst_one();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(st(0, 'b0011, 'b0011, mk(0, 3, 0, 0, 0)));
        for (int r = 0; r < 3; r++) begin
            s.push_back(st(0, 'b0011, 'b0011, mk('b0001, 0, 0, 1, 1)));
            s.push_back(st(0, 'b0011, 'b0011, mk(0, 0, 0, 1, 0)));
            s.push_back(st(0, 'b0011, 'b0011, mk('b0010, 1, 0, 1, 1)));
            s.push_back(st(0, 'b0011, 'b0011, mk(0, 1, 0, 1, 0)));
        end
        s.push_back(st(0, 'b0000, 'b0011, mk('b0001, 0, 0, 1, 0)));
        s.push_back(st(0, 'b0000, 'b0000, mk(0, 0, 0, 1, 0)));
        s.push_back(st(0, 'b0000, 'b0000, mk(0, 0, 0, 0, 0)));
        foreach (s[c]) begin
            rst = s[c].rst; req = s[c].req; inc = s[c].inc;
            sb.push_back(s[c].e);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs1 !== e) begin
                n_errors++;
                $display("FAIL max_burst_one cyc=%0d gnt/owner/burst/busy/up got=%b want=%b", c, obs1, e);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        inc = 4'b0000;
        test_reset();
        test_single();
        test_all_req();
        test_drop();
        test_inc_mask();
        test_fairness();
        test_reset_mid();
        test_max_burst_one();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
